one_to_two_stream_demux: RTL

ONE_TO_TWO_STREAM_DEMUX -- requirements
Module: one_to_two_stream_demux

---
 rtl/demux_pkg.sv | 19 +
 rtl/demux_slot.sv | 50 +++++
 rtl/one_to_two_stream_demux.sv | 93 +++++++++
 3 files changed

// File: rtl/demux_pkg.sv
// +----------------------------------------------------------------------------+
// | demux_pkg                                                                  |
// | Shared slot state type and default counter width for the stream demux.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package demux_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    localparam int COUNT_W_DEFAULT = 8;

endpackage

`default_nettype wire

// File: rtl/demux_slot.sv
// +----------------------------------------------------------------------------+
// | demux_slot                                                                 |
// | One-entry holding slot: loads a word, presents it until drained.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module demux_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_can_load,
    output logic             o_xfer
);

    slot_state_t      r_state;
    logic [WIDTH-1:0] r_data;
    logic             w_xfer;

    assign w_xfer = (r_state == FULL) && i_ready;

    // A load wins over a drain so a simultaneous drain+load keeps the slot full.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
            r_data  <= '0;
        end else if (i_load) begin
            r_state <= FULL;
            r_data  <= i_data;
        end else if (w_xfer) begin
            r_state <= EMPTY;
        end
    end

    assign o_valid    = (r_state == FULL);
    assign o_data     = r_data;
    assign o_can_load = (r_state == EMPTY) || i_ready;
    assign o_xfer     = w_xfer;

endmodule

`default_nettype wire

// File: rtl/one_to_two_stream_demux.sv
// +----------------------------------------------------------------------------+
// | one_to_two_stream_demux                                                    |
// | Routes a valid/ready stream to one of two independently draining outputs.  |
// | Optional macro DEMUX_COUNT_EN adds per-output transfer counters.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module one_to_two_stream_demux
    import demux_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = COUNT_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   out0_data,
    output logic               out0_valid,
    input  logic               out0_ready,
    output logic [WIDTH-1:0]   out1_data,
    output logic               out1_valid,
    input  logic               out1_ready
`ifdef DEMUX_COUNT_EN
    ,
    output logic [COUNT_W-1:0] cnt0,
    output logic [COUNT_W-1:0] cnt1
`endif
);

    logic w_can0;
    logic w_can1;
    logic w_accept;
    logic w_xfer0;
    logic w_xfer1;

    // Readiness follows only the selected slot, so a stalled peer never blocks.
    assign in_ready = in_sel ? w_can1 : w_can0;
    assign w_accept = in_valid && in_ready;

    demux_slot #(.WIDTH(WIDTH)) u_slot0 (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_accept && !in_sel),
        .i_data     (in_data),
        .i_ready    (out0_ready),
        .o_valid    (out0_valid),
        .o_data     (out0_data),
        .o_can_load (w_can0),
        .o_xfer     (w_xfer0)
    );

    demux_slot #(.WIDTH(WIDTH)) u_slot1 (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_accept && in_sel),
        .i_data     (in_data),
        .i_ready    (out1_ready),
        .o_valid    (out1_valid),
        .o_data     (out1_data),
        .o_can_load (w_can1),
        .o_xfer     (w_xfer1)
    );

`ifdef DEMUX_COUNT_EN
    logic [COUNT_W-1:0] r_cnt0;
    logic [COUNT_W-1:0] r_cnt1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_xfer0) r_cnt0 <= r_cnt0 + 1'b1;
            if (w_xfer1) r_cnt1 <= r_cnt1 + 1'b1;
        end
    end

    assign cnt0 = r_cnt0;
    assign cnt1 = r_cnt1;
`else
    logic                w_unused_xfer;
    logic [COUNT_W-1:0]  w_unused_cnt;
    assign w_unused_xfer = w_xfer0 ^ w_xfer1;
    assign w_unused_cnt  = '0;
`endif

endmodule

`default_nettype wire
